serial_descrambler: RTL and testbench

- Receiving end of a self-synchronising serial scrambled link (polynomial x^TAP_B + x^TAP_A + 1, default x^7+x^4+1).
- Takes one scrambled bit per accepted cycle and recovers the plaintext using the history of received bits.
- Assembles the descrambled bits MSB-first into WIDTH-bit words and presents each word on a valid/ready output handshake.
- Sits between the serial line front end and the word-oriented datapath.

---
 rtl/serial_descrambler.sv | 144 ++++++++++++++
 tb/tb_serial_descrambler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_descrambler.sv
// serial_descrambler
//   Receive side of a self-synchronising scrambled serial link using the
//   polynomial x^TAP_B + x^TAP_A + 1. Each accepted scrambled bit is
//   descrambled against the history of previously received line bits.
//   After TAP_B bits have filled that history, the descrambled bits are packed
//   MSB-first into WIDTH-bit words. Each word is offered on a valid/ready
//   output with a single holding register.
//
// Ports
//   clk       in   clock, rising-edge active
//   reset     in   synchronous active-high reset, clears all state
//   inBit     in   scrambled serial bit
//   inValid   in   inBit is present this cycle (no backpressure)
//   outWord   out  [WIDTH] descrambled word, MSB = earliest bit received
//   outValid  out  outWord holds an unconsumed word
//   outReady  in   consumer takes outWord when outValid && outReady
//   locked    out  history full, words are being assembled
//   overflow  out  sticky: a completed word found the holding register busy
module serial_descrambler #(
    parameter int WIDTH = 16,
    parameter int TAP_A = 4,
    parameter int TAP_B = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inBit,
    input  logic             inValid,
    output logic [WIDTH-1:0] outWord,
    output logic             outValid,
    input  logic             outReady,
    output logic             locked,
    output logic             overflow
);

    localparam int FILL_W = $clog2(TAP_B);
    localparam int BIT_W  = $clog2(WIDTH);

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(TAP_B - 1);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]  BIT_ZERO  = BIT_W'(0);

    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Plaintext bit = line bit xor the line bits TAP_A and TAP_B positions back.
    function automatic logic descramble_bit(input logic bit_in,
                                            input logic [TAP_B-1:0] hist);
        return bit_in ^ hist[TAP_A-1] ^ hist[TAP_B-1];
    endfunction

    logic [0:0]       state_r;
    logic [TAP_B-1:0] hist_r;      // hist_r[j] = line bit j+1 positions back
    logic [FILL_W-1:0] fill_cnt_r;
    logic [BIT_W-1:0] bit_cnt_r;
    // The oldest shifter bit is never observed: a completed word is built from
    // the lower WIDTH-1 bits plus the current bit, so only those are kept.
    logic [WIDTH-2:0] shift_r;
    logic [WIDTH-1:0] out_word_r;
    logic             out_valid_r;
    logic             locked_r;
    logic             overflow_r;

    logic             descr_bit_s;
    logic [WIDTH-1:0] word_s;
    logic             pop_s;
    logic             word_done_s;

    // Descrambled bit, candidate word, pop and word-completion decode.
    always_comb begin
        descr_bit_s = descramble_bit(inBit, hist_r);
        word_s      = {shift_r, descr_bit_s};
        pop_s       = out_valid_r && outReady;
        word_done_s = 1'b0;
        if (inValid && (state_r == ST_RUN) && (bit_cnt_r == BIT_LAST)) begin
            word_done_s = 1'b1;
        end else begin
            word_done_s = 1'b0;
        end
    end

    // Lock sequencing, word assembly and the output holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_SYNC;
            hist_r      <= {TAP_B{1'b0}};
            fill_cnt_r  <= {FILL_W{1'b0}};
            bit_cnt_r   <= {BIT_W{1'b0}};
            shift_r     <= {(WIDTH-1){1'b0}};
            out_word_r  <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            locked_r    <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            // A pop empties the holding register; a same-edge load below
            // overrides this and keeps outValid high.
            if (pop_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end

            if (inValid) begin
                hist_r <= {hist_r[TAP_B-2:0], inBit};
                case (state_r)
                    ST_SYNC: begin
                        if (fill_cnt_r == FILL_LAST) begin
                            state_r  <= ST_RUN;
                            locked_r <= 1'b1;
                        end else begin
                            fill_cnt_r <= fill_cnt_r + FILL_ONE;
                        end
                    end
                    ST_RUN: begin
                        shift_r <= word_s[WIDTH-2:0];
                        if (bit_cnt_r == BIT_LAST) begin
                            bit_cnt_r <= BIT_ZERO;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_ONE;
                        end
                        if (word_done_s) begin
                            if (!out_valid_r || pop_s) begin
                                out_word_r  <= word_s;
                                out_valid_r <= 1'b1;
                            end else begin
                                overflow_r <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_SYNC;
                    end
                endcase
            end
        end
    end

    assign outWord  = out_word_r;
    assign outValid = out_valid_r;
    assign locked   = locked_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_serial_descrambler.sv
// tb_serial_descrambler
//   Directed stimulus with hand-computed expected words. The driver pushes
//   each expected word when it starts sending that word; a separate monitor
//   pops and compares on every output handshake.
module tb_serial_descrambler;

    logic        clk;
    logic        reset;
    logic        inBit;
    logic        inValid;
    logic [15:0] outWord;
    logic        outValid;
    logic        outReady;
    logic        locked;
    logic        overflow;

    int n_cmp;
    int n_bad;
    logic [15:0] exp_q[$];

    serial_descrambler #(.WIDTH(16), .TAP_A(4), .TAP_B(7)) dut (
        .clk      (clk),
        .reset    (reset),
        .inBit    (inBit),
        .inValid  (inValid),
        .outWord  (outWord),
        .outValid (outValid),
        .outReady (outReady),
        .locked   (locked),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Handshakes happen on the next rising edge; sample on the falling edge.
    always @(negedge clk) begin
        if (!reset && outValid && outReady) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_word: got %h, expected no word", outWord);
            end else begin
                logic [15:0] exp_w;
                exp_w = exp_q.pop_front();
                if (outWord !== exp_w) begin
                    n_bad++;
                    $display("FAIL word: got %h, expected %h", outWord, exp_w);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        inValid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_bit(input logic b);
        inBit = b;
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    // Idle cycle with a garbage bit on the line that must be ignored.
    task automatic gap();
        inValid = 1'b0;
        inBit = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic sync_zeros();
        for (int i = 0; i < 7; i++) send_bit(1'b0);
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        inBit = 1'b0;
        inValid = 1'b0;
        outReady = 1'b1;
        n_cmp = 0;
        n_bad = 0;

        // Test 1: reset state, lock timing, all-zero word and its latency.
        do_reset();
        check("rst_outValid", 32'(outValid), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_outWord", 32'(outWord), 32'h0);
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b0);
            check($sformatf("t1_locked_bit%0d", i + 1), 32'(locked), (i == 6) ? 32'h1 : 32'h0);
        end
        exp_q.push_back(16'h0000);
        for (int i = 0; i < 15; i++) send_bit(1'b0);
        check("t1_valid_before_16th", 32'(outValid), 32'h0);
        send_bit(1'b0);
        check("t1_valid_after_16th", 32'(outValid), 32'h1);
        check("t1_word", 32'(outWord), 32'h0000);
        gap();
        check("t1_valid_popped", 32'(outValid), 32'h0);

        // Test 2: single one -> plaintext ones at k=0,4,7 -> 0x8900.
        do_reset();
        sync_zeros();
        exp_q.push_back(16'h8900);
        send_word(16'h8000);
        check("t2_valid", 32'(outValid), 32'h1);
        check("t2_word", 32'(outWord), 32'h8900);
        gap();
        check("t2_valid_pulse", 32'(outValid), 32'h0);

        // Test 3: no consumer; second word dropped, overflow sticky.
        do_reset();
        sync_zeros();
        outReady = 1'b0;
        exp_q.push_back(16'hF1FF);
        send_word(16'hFFFF);
        check("t3_overflow_first", 32'(overflow), 32'h0);
        send_word(16'h0000);
        check("t3_overflow_set", 32'(overflow), 32'h1);
        check("t3_word_held", 32'(outWord), 32'hF1FF);
        check("t3_valid_held", 32'(outValid), 32'h1);
        for (int i = 0; i < 3; i++) gap();
        check("t3_overflow_sticky", 32'(overflow), 32'h1);
        outReady = 1'b1;
        gap();
        check("t3_valid_after_pop", 32'(outValid), 32'h0);
        check("t3_overflow_after_pop", 32'(overflow), 32'h1);
        do_reset();
        check("t3_overflow_cleared", 32'(overflow), 32'h0);

        // Test 4: pop and load on the same edge.
        sync_zeros();
        outReady = 1'b0;
        exp_q.push_back(16'h8900);
        send_word(16'h8000);
        exp_q.push_back(16'hF1FF);
        for (int i = 15; i >= 1; i--) begin
            send_bit(1'b1);
            check("t4_valid_hold", 32'(outValid), 32'h1);
        end
        outReady = 1'b1;
        send_bit(1'b1);
        check("t4_valid_cont", 32'(outValid), 32'h1);
        check("t4_word_new", 32'(outWord), 32'hF1FF);
        check("t4_overflow", 32'(overflow), 32'h0);
        gap();
        check("t4_valid_popped", 32'(outValid), 32'h0);

        // Test 5: gapped feed gives the same word as a gapless one.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b0);
            gap();
        end
        check("t5_locked", 32'(locked), 32'h1);
        exp_q.push_back(16'hCD80);
        begin
            logic [15:0] v;
            v = 16'hC000;
            for (int i = 15; i >= 0; i--) begin
                send_bit(v[i]);
                if (i > 0) begin
                    gap();
                    check("t5_no_early_valid", 32'(outValid), 32'h0);
                end
            end
        end
        check("t5_valid", 32'(outValid), 32'h1);
        check("t5_word", 32'(outWord), 32'hCD80);
        gap();

        // Test 6: reset mid-word with a pending word discards everything.
        do_reset();
        sync_zeros();
        outReady = 1'b0;
        send_word(16'h8000);
        check("t6_pending_word", 32'(outWord), 32'h8900);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        do_reset();
        check("t6_valid_rst", 32'(outValid), 32'h0);
        check("t6_locked_rst", 32'(locked), 32'h0);
        check("t6_overflow_rst", 32'(overflow), 32'h0);
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b0);
            check($sformatf("t6_locked_bit%0d", i + 1), 32'(locked), (i == 6) ? 32'h1 : 32'h0);
        end
        outReady = 1'b1;
        exp_q.push_back(16'h0000);
        for (int i = 0; i < 15; i++) begin
            send_bit(1'b0);
            check("t6_no_early_valid", 32'(outValid), 32'h0);
        end
        send_bit(1'b0);
        check("t6_valid", 32'(outValid), 32'h1);
        check("t6_word", 32'(outWord), 32'h0000);
        gap();
        gap();
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
